wave_meter: RTL
===============

Name: wave_meter

Overview:
Receive-side counterpart of the waveform generator. It consumes the 8-bit wave sample stream (generator `wave_out`, qualified by a sample strobe) and measures max, min, peak-to-peak amplitude and period in samples. Lab closed-loop self-check: generator drives it, bench reads results.

Parameters:
DATA_W, 8, sample width
CNT_W, 16, period/timeout counter width
WIN, 512, samples in the amplitude-scan window (≥2)
HYST, 4, crossing hysteresis in LSBs

Ports:
clock  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
smp_en  input  1  wave_in valid this cycle; only strobed samples count
wave_in  input  DATA_W  unsigned sample
start  input  1  begin a measurement; ignored unless IDLE
busy  output  1  high from cycle after accepted start until done
done  output  1  one-cycle pulse when results are valid
vmax  output  DATA_W  max sample in window
vmin  output  DATA_W  min sample in window
vpp  output  DATA_W  vmax-vmin
period  output  CNT_W  samples between successive rising crossings
flat  output  1  vpp <= 2*HYST, no period measured
tmo  output  1  period measurement timed out
avg  output  DATA_W  window mean (see Optional Feature)

Behaviour:
- Reset: all outputs 0; state IDLE; counters cleared. Reset in any state aborts the measurement, with no done pulse.
- IDLE: start=1 -> AMP next cycle; busy=1 from that cycle. Results hold their last values until the next done.
- AMP: on the first accepted sample, load vmax=vmin=sample. Afterwards, vmax=max and vmin=min. Window counter counts accepted samples; after the WIN-th accepted sample -> CALC.
- CALC (1 cycle, no samples consumed):
  - vpp=vmax-vmin; mid=(vmax+vmin)>>1, computed as a DATA_W+1-bit sum.
  - If vpp <= 2*HYST: flat=1, period=0, tmo=0 -> DONE.
  - Else: lo_th=mid-HYST, hi_th=mid+HYST (no wrap possible given this guard); clear tcnt -> ARM.
- ARM: wait for an accepted sample <= lo_th -> RISE1.
- RISE1: wait for an accepted sample >= hi_th (the first crossing); tcnt=0 -> REARM.
- REARM: each accepted sample increments tcnt. When a sample <= lo_th arrives -> RISE2.
- RISE2: each accepted sample increments tcnt. When a sample >= hi_th arrives, period=tcnt+1 and tmo=0 -> DONE.
- Timeout:
  - In ARM/RISE1, tcnt counts accepted samples.
  - In any of ARM/RISE1/REARM/RISE2, if tcnt reaches 2^CNT_W-1: period=2^CNT_W-1, tmo=1, flat=0 -> DONE.
- DONE (1 cycle): done=1, busy=0 same cycle -> IDLE. start in DONE is ignored.
- Sample <= lo_th and >= hi_th are never simultaneously true, because hi_th > lo_th.
- smp_en=0 cycles freeze all counters and comparisons. smp_en is ignored in IDLE/CALC/DONE.
- Latency from the last window sample to CALC is 1 cycle; the final crossing sample to done is 1 cycle.

Optional Feature:
WAVE_METER_AVG_EN:
- Defined: a DATA_W+log2(WIN)-bit accumulator sums the window samples in AMP. In CALC, avg = sum/WIN (WIN a power of two -> shift; otherwise integer divide is allowed).
- Undefined: no accumulator is built; avg is constant 0.
- All other behaviour is identical.

Test Plan:
- Reset check: rst held 2 cycles mid-AMP -> all outputs 0, busy=0, no done; a subsequent start completes normally.
- Sawtooth 0..255 step 1, smp_en every cycle, start -> vmax=255, vmin=0, vpp=255, period=256, flat=0, tmo=0; avg=127 when AVG_EN is defined.
- Triangle 0->255->0 step 1 with smp_en every 3rd cycle -> vpp=255, period=510; sample count is unaffected by strobe gaps.
- Square wave alternating 50 samples of 0 and 50 of 200 -> vmax=200, vmin=0, mid=100, period=100.
- Constant 0x80 -> flat=1, vpp=0, period=0; done exactly 1 cycle after CALC, i.e. WIN accepted samples + 2 cycles after start.
- CNT_W=8, square wave with 400-sample half-period -> tmo=1, period=255. start pulsed while busy -> ignored, single done.

Source files
------------

// File: rtl/wave_meter.sv
// wave_meter: measures max/min/peak-to-peak/period of a strobed sample stream; WAVE_METER_AVG_EN adds a window mean
module wave_meter #(
  parameter int DATA_W = 8,
  parameter int CNT_W = 16,
  parameter int WIN = 512,
  parameter int HYST = 4
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              smp_en,
  input  logic [DATA_W-1:0] wave_in,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] vmax,
  output logic [DATA_W-1:0] vmin,
  output logic [DATA_W-1:0] vpp,
  output logic [CNT_W-1:0]  period,
  output logic              flat,
  output logic              tmo,
  output logic [DATA_W-1:0] avg
);
  typedef enum logic [2:0] {IDLE, AMP, CALC, ARM, RISE1, REARM, RISE2, DONE} state_t;
  localparam int WC_W = $clog2(WIN);
  localparam logic [CNT_W-1:0] TMAX = '1;
  localparam logic [DATA_W-1:0] HY = DATA_W'(HYST);
  localparam logic [DATA_W:0] HY2 = (DATA_W+1)'(2 * HYST);
  state_t state, nxt;
  logic [WC_W-1:0] wcnt;
  logic [CNT_W-1:0] tcnt;
  logic [DATA_W-1:0] cmax, cmin, lo_th, hi_th, dvpp, mid, avg_c;
  logic track, lo_hit, hi_hit, tout, last, flat_c, pub;
  assign dvpp = cmax - cmin;
  assign mid = DATA_W'(({1'b0, cmax} + {1'b0, cmin}) >> 1);
  assign flat_c = {1'b0, dvpp} <= HY2;
  assign track = state inside {ARM, RISE1, REARM, RISE2};
  assign lo_hit = smp_en && wave_in <= lo_th;
  assign hi_hit = smp_en && wave_in >= hi_th;
  assign tout = tcnt == TMAX;
  assign last = smp_en && wcnt == WC_W'(WIN - 1);
  assign pub = nxt == DONE;
`ifdef WAVE_METER_AVG_EN
  localparam int AW = DATA_W + $clog2(WIN);
  logic [AW-1:0] asum;
  assign avg_c = DATA_W'(asum / AW'(WIN));
  // window sample accumulator, cleared while idle
  always_ff @(posedge clock)
    if (rst || state == IDLE) asum <= '0;
    else if (state == AMP && smp_en) asum <= asum + AW'(wave_in);
`else
  assign avg_c = '0;
`endif
  // state register
  always_ff @(posedge clock) state <= rst ? IDLE : nxt;
  // next state; busy/done decoded from the current state
  always_comb begin
    nxt = state;
    busy = !(state == IDLE || state == DONE);
    done = state == DONE;
    case (state)
      IDLE:    nxt = start ? AMP : IDLE;
      AMP:     nxt = last ? CALC : AMP;
      CALC:    nxt = flat_c ? DONE : ARM;
      ARM:     nxt = tout ? DONE : lo_hit ? RISE1 : ARM;
      RISE1:   nxt = tout ? DONE : hi_hit ? REARM : RISE1;
      REARM:   nxt = tout ? DONE : lo_hit ? RISE2 : REARM;
      RISE2:   nxt = (tout || hi_hit) ? DONE : RISE2;
      default: nxt = IDLE;
    endcase
  end
  // window extremes, crossing thresholds and the period/timeout counter
  always_ff @(posedge clock) begin
    if (rst) begin
      wcnt <= '0;
      tcnt <= '0;
      cmax <= '0;
      cmin <= '0;
      lo_th <= '0;
      hi_th <= '0;
    end else begin
      if (state == IDLE) wcnt <= '0;
      if (state == AMP && smp_en) begin
        wcnt <= wcnt + WC_W'(1);
        cmax <= (wcnt == '0 || wave_in > cmax) ? wave_in : cmax;
        cmin <= (wcnt == '0 || wave_in < cmin) ? wave_in : cmin;
      end
      if (state == CALC) begin
        lo_th <= mid - HY;
        hi_th <= mid + HY;
        tcnt <= '0;
      end
      if (track && smp_en) tcnt <= (state == RISE1 && hi_hit) ? '0 : tcnt + CNT_W'(1);
    end
  end
  // results are published only on the way into DONE and held otherwise
  always_ff @(posedge clock) begin
    if (rst) begin
      vmax <= '0;
      vmin <= '0;
      vpp <= '0;
      avg <= '0;
      flat <= 1'b0;
      tmo <= 1'b0;
      period <= '0;
    end else if (pub) begin
      vmax <= cmax;
      vmin <= cmin;
      vpp <= dvpp;
      avg <= avg_c;
      flat <= state == CALC;
      tmo <= state != CALC && tout;
      period <= state == CALC ? '0 : tout ? TMAX : tcnt + CNT_W'(1);
    end
  end
endmodule
